// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared FSM encoding and address field positions for the direct-mapped cache responder
package dm_cache_pkg;
    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFF_LSB = 1;
    localparam int OFF_W = 2;
    localparam int IDX_LSB = 3;
endpackage

// File: rtl/dm_cache_responder_mem.sv
// banked_backing_mem: 64K x 16 store with a fixed MEM_LAT-cycle start/done handshake; contents survive reset
module banked_backing_mem #(
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        done,
    output logic [15:0] rdata
);
    localparam int CW = $clog2(MEM_LAT) + 1;
    logic [15:0] mem [65536];
    logic [15:0] addrQ, wdataQ;
    logic [CW-1:0] cnt;
    logic busy, wrQ;
    assign done = busy && cnt == CW'(MEM_LAT);
    assign rdata = mem[addrQ];
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
        end else if (start && (!busy || done)) begin
            busy <= 1'b1;
            cnt <= CW'(1);
            wrQ <= wr;
            addrQ <= addr;
            wdataQ <= wdata;
        end else if (done) begin
            busy <= 1'b0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst && done && wrQ) mem[addrQ] <= wdataQ;
    end
endmodule

// File: rtl/dm_cache_responder.sv
// dm_cache_responder: direct-mapped write-through no-write-allocate cache responder over a fixed-latency memory
module dm_cache_responder
    import dm_cache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 16 - IDX_LSB - IW;
    state_t state, nextState;
    logic [LINES-1:0] valid;
    logic [TW-1:0] tags [LINES];
    logic [15:0] lineData [LINES][WORDS_PER_LINE];
    logic [15:1] addrQ;
    logic [15:0] respData, memAddr, memRdata;
    logic [1:0] wordCnt, nextWord, off, qOff;
    logic [IW-1:0] idx, qIdx;
    logic [TW-1:0] tag;
    logic hit, hitQ, badReq, memStart, memWr, memDone, unusedDump;
    assign unusedDump = createdump;
    assign off = Addr[OFF_LSB +: OFF_W];
    assign idx = Addr[IDX_LSB +: IW];
    assign tag = Addr[15:IDX_LSB+IW];
    assign qOff = addrQ[2:1];
    assign qIdx = addrQ[IDX_LSB +: IW];
    assign nextWord = wordCnt + 2'd1;
    assign hit = valid[idx] && tags[idx] == tag;
    assign badReq = (Rd || Wr) && (Addr[0] || (Rd && Wr));
    always_comb begin
        nextState = state;
        Done = 1'b0;
        Stall = 1'b0;
        CacheHit = 1'b0;
        err = 1'b0;
        DataOut = '0;
        memStart = 1'b0;
        memWr = 1'b0;
        memAddr = {addrQ[15:3], nextWord, 1'b0};
        case (state)
            IDLE: begin
                if (badReq) begin
                    Done = 1'b1;
                    err = 1'b1;
                end else if (Rd && hit) begin
                    Done = 1'b1;
                    CacheHit = 1'b1;
                    DataOut = lineData[idx][off];
                end else if (Rd || Wr) begin
                    Stall = 1'b1;
                    memStart = 1'b1;
                    memWr = Wr;
                    memAddr = Wr ? Addr : {Addr[15:3], 3'b000};
                    nextState = Wr ? WRITE : FILL;
                end
            end
            FILL: begin
                Stall = 1'b1;
                memStart = memDone && wordCnt != 2'd3;
                nextState = (memDone && wordCnt == 2'd3) ? RESP : FILL;
            end
            WRITE: begin
                Stall = 1'b1;
                nextState = memDone ? RESP : WRITE;
            end
            RESP: begin
                Done = 1'b1;
                CacheHit = hitQ;
                DataOut = respData;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            valid <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && nextState == FILL) begin
                addrQ <= Addr[15:1];
                wordCnt <= 2'd0;
                hitQ <= 1'b0;
                valid[idx] <= 1'b0;
            end
            if (state == IDLE && nextState == WRITE) begin
                addrQ <= Addr[15:1];
                hitQ <= hit;
                respData <= '0;
            end
            if (state == FILL && memDone) begin
                if (wordCnt == qOff) respData <= memRdata;
                if (wordCnt == 2'd3) valid[qIdx] <= 1'b1;
                else wordCnt <= nextWord;
            end
        end
    end
    // Tag is claimed at fill entry; valid stays low until the last word lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == IDLE && nextState == FILL) tags[idx] <= tag;
            if (state == IDLE && nextState == WRITE && hit) lineData[idx][off] <= DataIn;
            if (state == FILL && memDone) lineData[qIdx][wordCnt] <= memRdata;
        end
    end
    banked_backing_mem #(.MEM_LAT(MEM_LAT)) uMem (
        .clk(clk),
        .rst(rst),
        .start(memStart),
        .wr(memWr),
        .addr(memAddr),
        .wdata(DataIn),
        .done(memDone),
        .rdata(memRdata)
    );
endmodule

// File: tb/tb_dm_cache_responder.sv
// tb_dm_cache_responder: table-driven directed checks plus hand sequences for reset-abort, held requests and stall isolation
module tb_dm_cache_responder;
    logic clk = 1'b0, rst = 1'b0;
    logic [15:0] Addr = '0, DataIn = '0, DataOut;
    logic Rd = 1'b0, Wr = 1'b0, createdump = 1'b0;
    logic Done, Stall, CacheHit, err;
    int tests = 0, fails = 0;

    typedef struct {
        logic rd;
        logic wr;
        logic [15:0] a;
        logic [15:0] d;
        int lat;
        logic h;
        logic e;
        logic [15:0] q;
    } vec_t;
    vec_t vecs[20];

    dm_cache_responder dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
        .CacheHit(CacheHit), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic doReq(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] dout, output logic h, output logic e,
                         output logic st0, output logic stD);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        lat = -1; dout = '0; h = 1'b0; e = 1'b0; st0 = 1'b0; stD = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) st0 = Stall;
            if (Done) begin
                lat = c; dout = DataOut; h = CacheHit; e = err; stD = Stall;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    task automatic runRead(input string name, input logic [15:0] a, input int expLat, input logic expHit, input logic [15:0] expQ);
        int lat;
        logic [15:0] q;
        logic h, e, s0, sd;
        doReq(1'b1, 1'b0, a, 16'h0, lat, q, h, e, s0, sd);
        check({name, " lat"}, 32'(lat), 32'(expLat));
        check({name, " hit"}, 32'(h), 32'(expHit));
        check({name, " data"}, 32'(q), 32'(expQ));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 5,  1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 16'h0012, 16'h1234, 5,  1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'h0110, 16'h5555, 5,  1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 16'h4000, 16'hA5A5, 5,  1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 16'h0016, 16'hCAFE, 5,  1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 17, 1'b0, 1'b0, 16'hBEEF};
        vecs[6]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 0,  1'b1, 1'b0, 16'h1234};
        vecs[7]  = '{1'b1, 1'b0, 16'h0110, 16'h0000, 17, 1'b0, 1'b0, 16'h5555};
        vecs[8]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 17, 1'b0, 1'b0, 16'hBEEF};
        vecs[9]  = '{1'b0, 1'b1, 16'h0012, 16'hA5A5, 5,  1'b1, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 0,  1'b1, 1'b0, 16'hA5A5};
        vecs[11] = '{1'b1, 1'b0, 16'h0016, 16'h0000, 0,  1'b1, 1'b0, 16'hCAFE};
        vecs[12] = '{1'b0, 1'b1, 16'h4002, 16'h0777, 5,  1'b0, 1'b0, 16'h0000};
        vecs[13] = '{1'b1, 1'b0, 16'h4000, 16'h0000, 17, 1'b0, 1'b0, 16'hA5A5};
        vecs[14] = '{1'b1, 1'b0, 16'h4002, 16'h0000, 0,  1'b1, 1'b0, 16'h0777};
        vecs[15] = '{1'b1, 1'b0, 16'h0013, 16'h0000, 0,  1'b0, 1'b1, 16'h0000};
        vecs[16] = '{1'b1, 1'b1, 16'h0012, 16'h0000, 0,  1'b0, 1'b1, 16'h0000};
        vecs[17] = '{1'b0, 1'b1, 16'h0011, 16'hFFFF, 0,  1'b0, 1'b1, 16'h0000};
        vecs[18] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 0,  1'b1, 1'b0, 16'hA5A5};
        vecs[19] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0,  1'b1, 1'b0, 16'hBEEF};

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset Done", 32'(Done), 32'h0);
        check("reset Stall", 32'(Stall), 32'h0);
        check("reset CacheHit", 32'(CacheHit), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset DataOut", 32'(DataOut), 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            int lat;
            logic [15:0] q;
            logic h, e, s0, sd;
            doReq(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, lat, q, h, e, s0, sd);
            check($sformatf("v%0d lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d hit", i), 32'(h), 32'(vecs[i].h));
            check($sformatf("v%0d err", i), 32'(e), 32'(vecs[i].e));
            if (!vecs[i].e) check($sformatf("v%0d data", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("v%0d accept stall", i), 32'(s0), 32'(vecs[i].lat > 0));
            check($sformatf("v%0d done stall", i), 32'(sd), 32'h0);
        end

        // reset in the middle of a line fill
        Rd = 1'b1; Addr = 16'h0110;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("midfill Stall", 32'(Stall), 32'h1);
        check("midfill Done", 32'(Done), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; Rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("postrst Done", 32'(Done), 32'h0);
        check("postrst Stall", 32'(Stall), 32'h0);
        check("postrst CacheHit", 32'(CacheHit), 32'h0);
        check("postrst err", 32'(err), 32'h0);
        check("postrst DataOut", 32'(DataOut), 32'h0);
        @(posedge clk); #1;
        runRead("refetch 0110", 16'h0110, 17, 1'b0, 16'h5555);
        runRead("invalidated 4002", 16'h4002, 17, 1'b0, 16'h0777);

        // held request is re-serviced each cycle as a fresh hit
        Rd = 1'b1; Addr = 16'h4000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("held c%0d Done", c), 32'(Done), 32'h1);
            check($sformatf("held c%0d hit", c), 32'(CacheHit), 32'h1);
            check($sformatf("held c%0d data", c), 32'(DataOut), 32'hA5A5);
            @(posedge clk); #1;
        end
        Rd = 1'b0;
        @(posedge clk); #1;

        // inputs changing while stalled must not affect the latched write
        Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h1111;
        repeat (2) @(posedge clk);
        #1 Addr = 16'h0030; DataIn = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("stallwr Done", 32'(Done), 32'h1);
        check("stallwr hit", 32'(CacheHit), 32'h0);
        @(posedge clk); #1;
        Wr = 1'b0;
        @(posedge clk); #1;
        runRead("stallwr readback", 16'h0020, 17, 1'b0, 16'h1111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dm_cache_responder.md
Name: dm_cache_responder

Overview:
- Responder side of the instruction/data memory request interface: accepts Rd/Wr requests from a fetch or memory stage and returns Done/Stall/CacheHit/err/DataOut.
- Direct-mapped, write-through, no-write-allocate cache in front of a fixed-latency backing memory.
- Sits between the pipeline's fetch or memory unit and the word-addressed backing store.
- Drop-in target for any initiator that holds Rd or Wr until Done and gates its PC or pipeline on Stall.

Parameters:
- LINES, 32: number of cache lines; power of 2; index width IW = log2(LINES).
- MEM_LAT, 4: backing-memory cycles per word access; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets.
- Addr  in  16  byte address; word aligned.
- DataIn  in  16  write data.
- Rd  in  1  read request; held by initiator until Done.
- Wr  in  1  write request; held by initiator until Done.
- createdump  in  1  accepted, functionally ignored.
- DataOut  out  16  read data; valid only when Done=1 and err=0.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  responder busy; initiator must hold request stable.
- CacheHit  out  1  qualifies Done; 1 means the access hit in the cache.
- err  out  1  qualifies Done; 1 means the request was illegal.

Behaviour:
- Address split:
  - offset = Addr[2:1] (4 words per line).
  - index = Addr[IW+2:3].
  - tag = Addr[15:IW+3].
- Per-line state: valid bit, tag, and 4x16 data words.
- Reset:
  - All valid bits cleared; FSM goes to IDLE.
  - Done=0, Stall=0, CacheHit=0, err=0, DataOut=0.
  - Backing-memory contents are retained.
  - Reset during FILL or WRITE abandons the operation. Completed backing-memory writes remain; no partial line is left valid.
- FSM states: IDLE, FILL, WRITE, RESP.
- IDLE with no request: all outputs 0, Stall=0.
- IDLE, error request (Addr[0]=1, or Rd and Wr both 1):
  - Same cycle: Done=1, err=1, CacheHit=0, Stall=0.
  - No state change.
- IDLE, Rd hit (valid and tag match):
  - Same cycle, combinationally: Done=1, CacheHit=1, DataOut = line word[offset], Stall=0.
  - Zero wait states; stays in IDLE.
- IDLE, Rd miss:
  - Stall=1 combinationally in the same cycle.
  - Addr is latched; go to FILL with word counter 0.
- FILL:
  - Reads line words 0..3 in order, MEM_LAT cycles each.
  - Each word is written into the data array as it returns.
  - Tag is written on entry; valid is set only when word 3 is written.
  - After word 3, go to RESP.
- IDLE, Wr:
  - Stall=1 and the request is latched.
  - On a hit, the cached word is updated at acceptance.
  - On a miss, there is no allocation.
  - Go to WRITE.
- WRITE: backing-memory write takes MEM_LAT cycles, then go to RESP.
- RESP (one cycle):
  - Done=1, Stall=0, CacheHit = hit status latched at acceptance, err=0.
  - DataOut = latched-word data for reads; 0 for writes.
  - Next state is IDLE.
- Latency:
  - Read miss: accept cycle, then 4*MEM_LAT FILL cycles, then RESP. Done appears 4*MEM_LAT+1 cycles after acceptance (17 at default).
  - Write: Done appears MEM_LAT+1 cycles after acceptance.
- While Stall=1, changes on Addr/Rd/Wr/DataIn are ignored; the latched request governs.
- The request cycle after RESP is a fresh IDLE lookup, so a held request is re-serviced as a new access.
- Single outstanding access only.
- All arithmetic is unsigned. The word counter is 2 bits and the latency counter is log2(MEM_LAT)+1 bits; neither wraps past its terminal count.

Decomposition:
- Shared package/constants: FSM state encodings, WORDS_PER_LINE=4, offset/index/tag field-position constants.
- One sub-module, banked_backing_mem:
  - 64K x 16 word store with MEM_LAT-cycle busy/done handshake (start, wr, addr, wdata -> done, rdata).
  - Not cleared by reset.

Test Plan:
- Reset, then Rd 0x0010 (mem[0x0010]=0xBEEF) -> Stall=1 from the accept cycle; Done=1, CacheHit=0, DataOut=0xBEEF exactly 17 cycles after acceptance.
- Then Rd 0x0012 (mem=0x1234) -> Done=1, CacheHit=1, DataOut=0x1234 in the same cycle; Stall never rises.
- Conflict: Rd 0x0110 after the line at 0x0010 is filled -> miss (CacheHit=0, 17 cycles); next Rd 0x0010 misses again.
- Wr 0x0012 DataIn=0xA5A5 on a hit -> Done at +5 with CacheHit=1; next Rd 0x0012 hits with DataOut=0xA5A5. Wr 0x4000 (miss) -> CacheHit=0 and no allocation; a following Rd 0x4000 is a miss returning 0xA5A5 only if that value was written there.
- Rd 0x0013, and separately Rd=Wr=1 -> same-cycle Done=1, err=1, Stall=0; cache state unchanged.
- rst=0 at cycle 8 of a miss fill -> outputs 0 next cycle; re-issued Rd of the same address misses with full 17-cycle latency.
